coin_input_conditioner: RTL
===========================

Name: coin_input_conditioner

Overview:
- Front-end stage that sits directly upstream of the vending machine core and drives its coin-insert input.
- Takes raw, asynchronous, bouncy coin-slot sensor levels, one per denomination.
- Synchronises and debounces each sensor, then converts each rising edge into exactly one coin event.
- Buffers events in a small FIFO and issues them as single-cycle one-hot pulses on the core's coin input; issue can be stalled while a change return is in progress.

Parameters:
- NUM_COINS, 3, number of coin denominations; equals the core's kNumCoins.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a level change is accepted; minimum 2.
- FIFO_DEPTH, 4, coin-event buffer entries; power of 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- i_raw_coin  input  NUM_COINS  raw slot sensor levels, asynchronous, bit i = denomination i
- i_hold  input  1  stall issue (tie to core's i_trigger_return); events are retained
- o_input_coin  output  NUM_COINS  one-hot, single-cycle coin pulse to core i_input_coin
- o_coin_reject  output  NUM_COINS  single-cycle pulse: coin i overflowed and must be mechanically returned
- o_busy  output  1  any pending flag set or FIFO non-empty
- o_fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs 0.
  - Sync flops, debounced levels, counters, pending flags, FIFO pointers and arbiter pointer cleared.
  - FSM enters ARMING.
- Synchroniser: 2-flop chain per bit; all later logic uses the second-stage output s[i].
- Debounce, per bit:
  - A counter runs while s[i] differs from the debounced level d[i].
  - The counter clears whenever they are equal.
  - When s[i] has differed for DEBOUNCE_CYCLES consecutive cycles, d[i] takes s[i] and the counter clears.
- FSM:
  - ARMING:
    - Lasts DEBOUNCE_CYCLES+2 cycles after reset release, counted by an arm counter.
    - d[i] is loaded directly from s[i] each cycle; no events are generated.
    - A sensor stuck high through reset therefore never creates a coin.
    - Transition to RUN when the arm counter expires.
  - RUN: normal operation.
- Event detection (RUN only):
  - A 0->1 transition of d[i] sets pending[i] on the next edge.
  - If pending[i] is already set and not being cleared that cycle, pending[i] stays set and o_coin_reject[i] pulses for 1 cycle.
  - Falling edges of d[i] are ignored.
- Arbiter:
  - Each cycle, if the FIFO is not full, a round-robin choice selects one set pending bit, starting after the last granted index.
  - The selected index is written to the FIFO and its pending bit is cleared.
  - If the FIFO is full, pending bits hold and nothing is lost or rejected.
- FIFO:
  - Stores coin indices; read/write pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves the count unchanged and is legal at full and at empty.
  - o_fifo_count is registered, range 0..FIFO_DEPTH.
- Issue:
  - o_input_coin is registered.
  - If the FIFO is non-empty and i_hold=0, the head is popped and o_input_coin = one-hot(head) for exactly 1 cycle.
  - Back-to-back pulses on consecutive cycles are allowed.
  - If i_hold=1, o_input_coin = 0 and the FIFO holds.
  - i_hold going low resumes issue on the next cycle.
- Latency: a clean raw rise sampled at edge 0, with an idle block, gives o_input_coin high after edge DEBOUNCE_CYCLES+4.
  - Sync: edges 0–1.
  - Debounce: edge 1+D.
  - Pending: edge 2+D.
  - FIFO write: edge 3+D.
  - Issue: edge 4+D.
- o_busy = |pending | (count != 0), combinational from registers.
- Reset mid-operation: pending events and FIFO contents are discarded; no pulse is emitted during or after reset until the next qualified edge in RUN.

Test Plan:
- Reset release with i_raw_coin=3'b010 held high for 50 cycles -> o_input_coin never asserts; FSM in RUN after D+2=6 cycles.
- Clean pulse on bit0, held 10 cycles after arming, D=4 -> o_input_coin=3'b001 for exactly 1 cycle, 8 cycles after the first sampling edge; o_fifo_count returns to 0.
- Bit2 toggled 0/1 every cycle for 20 cycles, then held high -> exactly one 3'b100 pulse, no pulse during the glitch train.
- All three bits rise on the same cycle -> three one-hot pulses on consecutive cycles, in round-robin order 001, 010, 100; no reject.
- i_hold=1 while 6 coins on bit1 are debounced (FIFO_DEPTH=4) ->
  - o_fifo_count saturates at 4 and pending[1] holds.
  - The 6th rise pulses o_coin_reject=3'b010.
  - After i_hold=0, exactly 5 consecutive 3'b010 pulses are issued.
- reset_n asserted for 1 cycle with count=3 -> all outputs 0 immediately; no pulses after release; o_busy=0.

Source files
------------

// File: rtl/coin_input_conditioner.sv
// Coin-slot front end: synchronises and debounces raw sensor levels, turns
// each qualified rising edge into one coin event, buffers events in a small
// FIFO and issues them as single-cycle one-hot pulses to the vending core.
module coin_input_conditioner #(
  parameter int NUM_COINS       = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_COINS-1:0]          i_raw_coin,
  input  logic                          i_hold,
  output logic [NUM_COINS-1:0]          o_input_coin,
  output logic [NUM_COINS-1:0]          o_coin_reject,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int ARM_W = $clog2(DEBOUNCE_CYCLES + 2);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ARMING, RUN} state_e;

  // Index of the k-th candidate after base, wrapping modulo NUM_COINS.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_COINS) s = s - NUM_COINS;
    return IDX_W'(s);
  endfunction

  function automatic logic [NUM_COINS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_COINS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_e                 state_q, state_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [NUM_COINS-1:0]   sync1_q, sync2_q;
  logic [NUM_COINS-1:0]   deb_q, deb_d, deb_prev_q;
  logic [DB_W-1:0]        db_cnt_q [NUM_COINS];
  logic [DB_W-1:0]        db_cnt_d [NUM_COINS];
  logic [NUM_COINS-1:0]   rise;
  logic [NUM_COINS-1:0]   pending_q, pending_d;
  logic [NUM_COINS-1:0]   reject_q, reject_d;
  logic [NUM_COINS-1:0]   coin_q, coin_d;
  logic [NUM_COINS-1:0]   clear_mask;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_vld;
  logic [IDX_W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   push, pop;

  // Arming sequence: hold off event generation until the sync chain and
  // debounced levels reflect the real sensor state after reset.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    if (state_q == ARMING) begin
      if (arm_cnt_q == ARM_LAST) begin
        state_d   = RUN;
        arm_cnt_d = '0;
      end else begin
        arm_cnt_d = arm_cnt_q + ARM_W'(1);
      end
    end
  end

  // Per-bit debounce: accept a new level only after it has been stable for
  // DEBOUNCE_CYCLES samples; during arming track the synchronised input.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NUM_COINS; i++) begin
      db_cnt_d[i] = '0;
      if (state_q == ARMING) begin
        deb_d[i] = sync2_q[i];
      end else if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Round-robin pick of one pending coin, starting at rr_ptr_q.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (!grant_vld && pending_q[rr_index(rr_ptr_q, k)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_index(rr_ptr_q, k);
      end
    end
  end

  // Event capture, FIFO bookkeeping and issue; a push at full is allowed
  // only when the head is popped in the same cycle.
  always_comb begin
    rise       = (state_q == RUN) ? (deb_q & ~deb_prev_q) : '0;
    pop        = (count_q != '0) && !i_hold;
    push       = grant_vld && ((count_q != FULL) || pop);
    clear_mask = push ? onehot(grant_idx) : '0;
    pending_d  = (pending_q & ~clear_mask) | rise;
    reject_d   = rise & pending_q & ~clear_mask;
    rr_ptr_d   = push ? rr_index(grant_idx, 1) : rr_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (!push && pop) count_d = count_q - CNT_W'(1);
    coin_d     = pop ? onehot(mem_q[rd_ptr_q]) : '0;
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARMING;
      arm_cnt_q  <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      db_cnt_q   <= '{default: '0};
      pending_q  <= '0;
      reject_q   <= '0;
      coin_q     <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      sync1_q    <= i_raw_coin;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= (state_q == ARMING) ? sync2_q : deb_q;
      db_cnt_q   <= db_cnt_d;
      pending_q  <= pending_d;
      reject_q   <= reject_d;
      coin_q     <= coin_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= grant_idx;
  end

  assign o_input_coin  = coin_q;
  assign o_coin_reject = reject_q;
  assign o_fifo_count  = count_q;
  assign o_busy        = (|pending_q) | (count_q != '0);

endmodule
